// File: rtl/inst_fetch_if.sv
// Fetch-unit bus: instruction-memory request/response plus the decoder-side
// inst handshake and branch stall/resolve signals.
interface inst_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        stall;
  logic        resolve_valid;
  logic        resolve_taken;
  logic [31:0] resolve_target;

  modport master (
    output imem_req, imem_addr, inst, inst_pc, inst_valid,
    input  imem_ready, imem_rvalid, imem_rdata, inst_ready, stall,
           resolve_valid, resolve_taken, resolve_target
  );

  modport slave (
    input  imem_req, imem_addr, inst, inst_pc, inst_valid,
    output imem_ready, imem_rvalid, imem_rdata, inst_ready, stall,
           resolve_valid, resolve_taken, resolve_target
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: in-order imem word reads into a small {pc,word} FIFO that
// feeds the decoder; halts on a branch stall until the branch resolves.
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MAX_OUTST = 2,
  parameter int          BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  typedef enum logic {FETCH, WAIT_BR} state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  state_e                 state_q, state_d;
  logic [31:0]            pc_q, pc_d, br_pc_q, br_pc_d;
  logic [OW-1:0]          outst_q, outst_d, discard_q, discard_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
  ent_t [BUF_DEPTH-1:0]   buf_q, buf_d;

  logic        req, req_fire, pop, push, br_acc, rsp_drop;
  logic [31:0] rsp_pc;
  int          credit;
  ent_t        head_ent;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head_ent       = buf_q[head_q];
  assign bus.inst       = head_ent.word;
  assign bus.inst_pc    = head_ent.pc;
  assign bus.inst_valid = (state_q == FETCH) && (cnt_q != '0);
  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc_q;

  assign pop      = bus.inst_valid && bus.inst_ready;
  assign br_acc   = pop && bus.stall;
  assign rsp_drop = bus.imem_rvalid && (discard_q != '0);
  assign push     = bus.imem_rvalid && (discard_q == '0) && !br_acc;
  // Live requests are contiguous and end at pc_q-4, so the oldest one is
  // pc_q - 4*outstanding.
  assign rsp_pc   = pc_q - (32'(outst_q) << 2);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    br_pc_d   = br_pc_q;
    outst_d   = outst_q;
    discard_d = discard_q;
    cnt_d     = cnt_q;
    head_d    = head_q;
    tail_d    = tail_q;
    buf_d     = buf_q;

    // A slot freed by this cycle's pop is already usable, which is what
    // keeps a 1-cycle imem streaming at one instruction per cycle.
    credit   = int'(outst_q) + int'(cnt_q) - int'(pop);
    req      = !rst && (state_q == FETCH) && (discard_q == '0) &&
               (int'(outst_q) < MAX_OUTST) && (credit < BUF_DEPTH);
    req_fire = req && bus.imem_ready;

    if (req_fire) pc_d = pc_q + 32'd4;
    outst_d = outst_q + OW'(req_fire) - OW'(bus.imem_rvalid);
    if (rsp_drop) discard_d = discard_q - OW'(1);

    if (push) begin
      buf_d[tail_q] = '{pc: rsp_pc, word: bus.imem_rdata};
      tail_d        = ptr_inc(tail_q);
    end
    if (pop) head_d = ptr_inc(head_q);
    cnt_d = cnt_q + CW'(push) - CW'(pop);

    case (state_q)
      FETCH: begin
        if (br_acc) begin
          state_d = WAIT_BR;
          br_pc_d = bus.inst_pc;
          cnt_d   = '0;
          head_d  = tail_q;
          // Buffer is empty whenever discard is nonzero, so a branch can only
          // be accepted with discard==0: every remaining in-flight word is junk.
          discard_d = outst_d;
        end
      end
      WAIT_BR: begin
        if (bus.resolve_valid) begin
          state_d = FETCH;
          pc_d    = bus.resolve_taken ? (bus.resolve_target & 32'hFFFF_FFFC)
                                      : br_pc_q + 32'd4;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      br_pc_q   <= '0;
      outst_q   <= '0;
      discard_q <= '0;
      cnt_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      buf_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      br_pc_q   <= br_pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      cnt_q     <= cnt_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      buf_q     <= buf_d;
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: imem model with settable latency, expected-pc
// scoreboard drained by a decoder-side monitor, plus per-cycle bus checks.
module tb_inst_fetch;
  logic clk, rst;
  int   lat;
  logic br_en, stall_force;
  int   total, bad;
  logic [31:0] sb[$];
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          cyc;

  inst_fetch_if bus();

  inst_fetch #(.RESET_PC(32'h0), .MAX_OUTST(2), .BUF_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.stall = stall_force | (br_en & bus.inst_valid & (bus.inst_pc == 32'h10));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // imem model: in-order responses lat cycles after accept; forgets on reset
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else begin
        bus.imem_rvalid = 1'b0;
      end
      @(negedge clk);
      if (rst) begin
        mq_addr.delete();
        mq_due.delete();
      end else if (bus.imem_req && bus.imem_ready) begin
        mq_addr.push_back(bus.imem_addr);
        mq_due.push_back(cyc + lat);
      end
    end
  end

  // decoder-side monitor: every accepted inst must match the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (bus.inst_valid && bus.inst_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_extra: got pc %h want no accept", bus.inst_pc);
        end else begin
          logic [31:0] e;
          e = sb.pop_front();
          chk("sb_pc", bus.inst_pc, e);
          chk("sb_inst", bus.inst, mem_word(e));
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.inst_ready = 1'b0;
    bus.imem_ready = 1'b1;
    bus.resolve_valid = 1'b0;
    bus.resolve_taken = 1'b0;
    bus.resolve_target = '0;
    br_en = 1'b0;
    stall_force = 1'b0;
    step();
    step();
    smp();
    chk("rst_req", 32'(bus.imem_req), 0);
    chk("rst_valid", 32'(bus.inst_valid), 0);
    chk("rst_inst", bus.inst, 0);
    chk("rst_pc", bus.inst_pc, 0);
    sb.delete();
    step();
    rst = 1'b0;
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) sb.push_back(base + 32'(4 * i));
  endtask

  task automatic consume();
    int n;
    n = 0;
    bus.inst_ready = 1'b1;
    while (sb.size() != 0 && n < 60) begin
      step();
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL consume_timeout: got %0d left want 0", sb.size());
      sb.delete();
    end
    bus.inst_ready = 1'b0;
  endtask

  task automatic br_case(input bit taken);
    logic [31:0] nxt;
    nxt = taken ? 32'h100 : 32'h14;
    lat = 2;
    do_reset();
    push_seq(32'h0, 3);
    consume();
    repeat (4) step();
    br_en = 1'b1;
    push_seq(32'hC, 2);
    bus.inst_ready = 1'b1;
    smp();
    chk("br_req_a", bus.imem_addr, 32'h14);
    step();
    smp();
    chk("br_acc_pc", bus.inst_pc, 32'h10);
    chk("br_simreq", bus.imem_addr, 32'h18);
    chk("br_simreq_v", 32'(bus.imem_req), 1);
    step();
    bus.inst_ready = 1'b0;
    br_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("wait_req", 32'(bus.imem_req), 0);
      chk("wait_valid", 32'(bus.inst_valid), 0);
      step();
    end
    bus.resolve_valid = 1'b1;
    bus.resolve_taken = taken;
    bus.resolve_target = 32'h103;
    smp();
    chk("res_req", 32'(bus.imem_req), 0);
    step();
    bus.resolve_valid = 1'b0;
    smp();
    chk("res_addr", bus.imem_addr, nxt);
    chk("res_reqv", 32'(bus.imem_req), 1);
    chk("res_novalid", 32'(bus.inst_valid), 0);
    step();
    smp();
    chk("res_novalid2", 32'(bus.inst_valid), 0);
    step();
    push_seq(nxt, 3);
    consume();
  endtask

  initial begin
    total = 0;
    bad = 0;
    lat = 1;
    rst = 1'b1;
    br_en = 1'b0;
    stall_force = 1'b0;
    bus.inst_ready = 1'b0;
    bus.imem_ready = 1'b1;
    bus.resolve_valid = 1'b0;
    bus.resolve_taken = 1'b0;
    bus.resolve_target = '0;

    // 1: streaming, 1-cycle imem
    do_reset();
    push_seq(32'h0, 8);
    bus.inst_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      smp();
      chk("t1_req", 32'(bus.imem_req), 1);
      chk("t1_addr", bus.imem_addr, 32'(4 * k));
      chk("t1_valid", 32'(bus.inst_valid), (k >= 2) ? 1 : 0);
      if (k >= 2) chk("t1_pc", bus.inst_pc, 32'(4 * (k - 2)));
      step();
    end
    bus.inst_ready = 1'b0;

    // 2: decoder back-pressure; stray stall/resolve must be ignored
    for (int k = 0; k < 5; k++) begin
      stall_force = (k == 0);
      bus.resolve_valid = (k == 1);
      bus.resolve_taken = 1'b1;
      bus.resolve_target = 32'h200;
      smp();
      chk("t2_noreq", 32'(bus.imem_req), 0);
      chk("t2_hold_v", 32'(bus.inst_valid), 1);
      chk("t2_hold_pc", bus.inst_pc, 32'h20);
      chk("t2_hold_in", bus.inst, mem_word(32'h20));
      step();
    end
    stall_force = 1'b0;
    bus.resolve_valid = 1'b0;
    push_seq(32'h20, 8);
    consume();

    // 3: branch with two in flight, not taken then taken
    br_case(1'b0);
    br_case(1'b1);

    // 4: imem back-pressure
    lat = 1;
    do_reset();
    bus.imem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("t4_req", 32'(bus.imem_req), 1);
      chk("t4_addr", bus.imem_addr, 32'h0);
      step();
    end
    bus.imem_ready = 1'b1;
    smp();
    chk("t4_acc", bus.imem_addr, 32'h0);
    step();
    smp();
    chk("t4_next", bus.imem_addr, 32'h4);
    step();
    push_seq(32'h0, 3);
    consume();

    // 5: reset mid-stream
    do_reset();
    push_seq(32'h0, 2);
    bus.inst_ready = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    smp();
    step();
    bus.inst_ready = 1'b0;
    smp();
    chk("t5_req", 32'(bus.imem_req), 0);
    chk("t5_valid", 32'(bus.inst_valid), 0);
    chk("t5_inst", bus.inst, 0);
    chk("t5_pc", bus.inst_pc, 0);
    step();
    rst = 1'b0;
    smp();
    chk("t5_req1", 32'(bus.imem_req), 1);
    chk("t5_addr1", bus.imem_addr, 32'h0);
    step();

    // 6: branch accepted with its fall-through word arriving the same cycle
    do_reset();
    br_en = 1'b1;
    push_seq(32'h0, 5);
    bus.inst_ready = 1'b1;
    repeat (6) step();
    smp();
    chk("t6_acc_pc", bus.inst_pc, 32'h10);
    chk("t6_rsp", 32'(bus.imem_rvalid), 1);
    chk("t6_simreq", bus.imem_addr, 32'h18);
    step();
    bus.inst_ready = 1'b0;
    br_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      smp();
      chk("t6_wait_req", 32'(bus.imem_req), 0);
      step();
    end
    bus.resolve_valid = 1'b1;
    bus.resolve_taken = 1'b0;
    smp();
    step();
    bus.resolve_valid = 1'b0;
    smp();
    chk("t6_res_req", 32'(bus.imem_req), 1);
    chk("t6_res_addr", bus.imem_addr, 32'h14);
    step();
    smp();
    chk("t6_novalid", 32'(bus.inst_valid), 0);
    step();
    push_seq(32'h14, 3);
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
